hilo_div_seq: RTL



---
 rtl/cpu_pkg.sv | 18 +
 rtl/hilo_div_seq_if.sv | 25 ++
 rtl/hilo_div_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: divider state encoding and timing constants
// used by the HI/LO divider, the hazard unit and the divider bench.
package cpu_pkg;

   localparam int WORD_W      = 32;
   localparam int DIV_ITERS   = WORD_W;
   // Edges from the accepting start edge until done is visible: PREP, WORD_W iterations, FIX.
   localparam int DIV_LATENCY = DIV_ITERS + 2;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } div_state_t;

endpackage

// File: rtl/hilo_div_seq_if.sv
// Request/response bundle between the execute stage and the HI/LO divider.
interface hilo_div_seq_if #(
   parameter int WIDTH = cpu_pkg::WORD_W
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output start, is_signed, dividend, divisor, cancel,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor, cancel,
      output busy, done, quotient, remainder, div_zero
   );
endinterface

// File: rtl/hilo_div_seq.sv
// Iterative restoring divider feeding HI (remainder) and LO (quotient) for div/divu.
// Signed operands are divided as magnitudes and the signs are restored at the end.
module hilo_div_seq
   import cpu_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic           clock,
   input  logic           rst_n,
   hilo_div_seq_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_t       state_q, state_d;
   logic             mode_signed_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dq_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] quo_out_q;
   logic [WIDTH-1:0] rem_out_q;
   logic             dz_out_q;

   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] dq_step;

   // Datapath: operand magnitudes and one restoring shift/subtract step.
   always_comb begin
      mag_a  = (mode_signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
      mag_b  = (mode_signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
      rem_sh = {rem_q, dq_q[WIDTH-1]};
      // One extra bit so an unsigned divisor near 2**WIDTH still yields a valid borrow.
      trial  = rem_sh - {1'b0, b_q};
      if (!trial[WIDTH]) begin
         rem_step = trial[WIDTH-1:0];
         dq_step  = {dq_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_step = rem_sh[WIDTH-1:0];
         dq_step  = {dq_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.start && !bus.cancel) state_d = PREP;
         PREP: begin
            if (bus.cancel)      state_d = IDLE;
            else if (b_q == '0)  state_d = DONE;
            else                 state_d = CALC;
         end
         CALC: begin
            if (bus.cancel)                      state_d = IDLE;
            else if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
         end
         FIX:  state_d = bus.cancel ? IDLE : DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         mode_signed_q <= 1'b0;
         neg_quo_q     <= 1'b0;
         neg_rem_q     <= 1'b0;
         a_q           <= '0;
         b_q           <= '0;
         rem_q         <= '0;
         dq_q          <= '0;
         cnt_q         <= '0;
         quo_out_q     <= '0;
         rem_out_q     <= '0;
         dz_out_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start && !bus.cancel) begin
                  mode_signed_q <= bus.is_signed;
                  a_q           <= bus.dividend;
                  b_q           <= bus.divisor;
               end
            end
            PREP: begin
               if (!bus.cancel) begin
                  if (b_q == '0) begin
                     quo_out_q <= '1;
                     rem_out_q <= a_q;
                     dz_out_q  <= 1'b1;
                  end else begin
                     neg_quo_q <= mode_signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                     neg_rem_q <= mode_signed_q && a_q[WIDTH-1];
                     b_q       <= mag_b;
                     rem_q     <= '0;
                     dq_q      <= mag_a;
                     cnt_q     <= '0;
                  end
               end
            end
            CALC: begin
               if (!bus.cancel) begin
                  rem_q <= rem_step;
                  dq_q  <= dq_step;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            FIX: begin
               // The quotient of -2**(WIDTH-1) / -1 wraps back to -2**(WIDTH-1) without help.
               if (!bus.cancel) begin
                  quo_out_q <= neg_quo_q ? -dq_q : dq_q;
                  rem_out_q <= neg_rem_q ? -rem_q : rem_q;
                  dz_out_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.busy      = (state_q == PREP) || (state_q == CALC) || (state_q == FIX);
      bus.done      = (state_q == DONE);
      bus.quotient  = quo_out_q;
      bus.remainder = rem_out_q;
      bus.div_zero  = dz_out_q;
   end

endmodule
